// File: rtl/text_frame_buffer.sv
// ---------------------------------------------------------------------------
// text_frame_buffer
//
// Character/attribute store plus a terminal-style write engine for the VGA
// text output stage. The display side reads one 80x60 cell per clock with a
// single cycle of latency; the CPU side streams bytes in through a
// valid/ready handshake. Printable bytes land at a hardware cursor, and
// control codes move the cursor or blank the screen.
//
// Ports:
//   clk           pixel clock, shared with the VGA output stage
//   reset         synchronous, active-high
//   characterPos  display read address, [12:6] column, [5:0] row
//   character     registered character code for characterPos
//   fgColor       registered foreground colour for characterPos
//   bgColor       registered background colour for characterPos
//   cmdValid      cmdData holds a byte this cycle
//   cmdData       printable byte or control code
//   cmdReady      engine accepts a byte this cycle
//   colorWrite    load newFg/newBg into the current colour registers
//   newFg         new current foreground colour
//   newBg         new current background colour
//   cursorCol     current cursor column
//   cursorRow     current cursor row
// ---------------------------------------------------------------------------
module text_frame_buffer #(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 60,
    parameter logic [2:0] DEFAULT_FG = 3'b111,
    parameter logic [2:0] DEFAULT_BG = 3'b000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] characterPos,
    output logic [7:0]  character,
    output logic [2:0]  fgColor,
    output logic [2:0]  bgColor,
    input  logic        cmdValid,
    input  logic [7:0]  cmdData,
    output logic        cmdReady,
    input  logic        colorWrite,
    input  logic [2:0]  newFg,
    input  logic [2:0]  newBg,
    output logic [6:0]  cursorCol,
    output logic [5:0]  cursorRow
);

    typedef enum logic [1:0] {CLEAR_ALL, CLEAR_ROW, IDLE} state_t;

    localparam logic [6:0] NUM_COLS = 7'(COLS);
    localparam logic [5:0] NUM_ROWS = 6'(ROWS);
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);
    localparam logic [7:0] BLANK    = 8'h20;

    // Each cell is {char[7:0], fg[2:0], bg[2:0]}, addressed as {col, row}.
    logic [13:0] mem [0:8191];

    state_t      state_q, state_d;
    logic [6:0]  curCol_q, curCol_d;
    logic [5:0]  curRow_q, curRow_d;
    logic [2:0]  fg_q, fg_d;
    logic [2:0]  bg_q, bg_d;
    logic [2:0]  clrFg_q, clrFg_d;
    logic [2:0]  clrBg_q, clrBg_d;
    logic [6:0]  sweepCol_q, sweepCol_d;
    logic [5:0]  sweepRow_q, sweepRow_d;

    logic        memWe;
    logic [12:0] memAddr;
    logic [13:0] memData;
    logic        accept;
    logic        newline;
    logic        printable;

    logic [13:0] rdData_q;
    logic        blank_q;

    assign cmdReady  = (state_q == IDLE) && !reset;
    assign accept    = cmdValid && cmdReady;
    assign printable = (cmdData >= 8'h20) && (cmdData <= 8'h7F);
    assign cursorCol = curCol_q;
    assign cursorRow = curRow_q;

    // Next-state logic: sweeps own the write port while clearing; in IDLE an
    // accepted byte may write one cell and move the cursor. A newline always
    // hands over to a row sweep of the row the cursor lands on.
    always_comb begin
        state_d    = state_q;
        curCol_d   = curCol_q;
        curRow_d   = curRow_q;
        fg_d       = colorWrite ? newFg : fg_q;
        bg_d       = colorWrite ? newBg : bg_q;
        clrFg_d    = clrFg_q;
        clrBg_d    = clrBg_q;
        sweepCol_d = sweepCol_q;
        sweepRow_d = sweepRow_q;
        memWe      = 1'b0;
        memAddr    = {curCol_q, curRow_q};
        memData    = {BLANK, fg_q, bg_q};
        newline    = 1'b0;

        case (state_q)
            CLEAR_ALL: begin
                // Rows run fastest so the sweep walks the address space in order.
                memWe   = 1'b1;
                memAddr = {sweepCol_q, sweepRow_q};
                memData = {BLANK, clrFg_q, clrBg_q};
                if (sweepRow_q == LAST_ROW) begin
                    sweepRow_d = '0;
                    if (sweepCol_q == LAST_COL) begin
                        sweepCol_d = '0;
                        state_d    = IDLE;
                    end else begin
                        sweepCol_d = sweepCol_q + 7'd1;
                    end
                end else begin
                    sweepRow_d = sweepRow_q + 6'd1;
                end
            end
            CLEAR_ROW: begin
                memWe   = 1'b1;
                memAddr = {sweepCol_q, curRow_q};
                memData = {BLANK, clrFg_q, clrBg_q};
                if (sweepCol_q == LAST_COL) begin
                    sweepCol_d = '0;
                    state_d    = IDLE;
                end else begin
                    sweepCol_d = sweepCol_q + 7'd1;
                end
            end
            IDLE: begin
                if (accept) begin
                    if (printable) begin
                        // Written with the colours in force before any
                        // simultaneous colorWrite.
                        memWe   = 1'b1;
                        memAddr = {curCol_q, curRow_q};
                        memData = {cmdData, fg_q, bg_q};
                        if (curCol_q == LAST_COL) begin
                            newline = 1'b1;
                        end else begin
                            curCol_d = curCol_q + 7'd1;
                        end
                    end else begin
                        case (cmdData)
                            8'h0A: newline  = 1'b1;
                            8'h0D: curCol_d = '0;
                            8'h08: begin
                                if (curCol_q != '0) begin
                                    curCol_d = curCol_q - 7'd1;
                                    memWe    = 1'b1;
                                    memAddr  = {curCol_d, curRow_q};
                                    memData  = {BLANK, fg_q, bg_q};
                                end
                            end
                            8'h0C: begin
                                curCol_d   = '0;
                                curRow_d   = '0;
                                sweepCol_d = '0;
                                sweepRow_d = '0;
                                clrFg_d    = fg_q;
                                clrBg_d    = bg_q;
                                state_d    = CLEAR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (newline) begin
            curCol_d   = '0;
            curRow_d   = (curRow_q == LAST_ROW) ? 6'd0 : curRow_q + 6'd1;
            sweepCol_d = '0;
            clrFg_d    = fg_q;
            clrBg_d    = bg_q;
            state_d    = CLEAR_ROW;
        end
    end

    // Engine state register; reset restarts a full-screen clear from cell 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR_ALL;
            curCol_q   <= '0;
            curRow_q   <= '0;
            fg_q       <= DEFAULT_FG;
            bg_q       <= DEFAULT_BG;
            clrFg_q    <= DEFAULT_FG;
            clrBg_q    <= DEFAULT_BG;
            sweepCol_q <= '0;
            sweepRow_q <= '0;
        end else begin
            state_q    <= state_d;
            curCol_q   <= curCol_d;
            curRow_q   <= curRow_d;
            fg_q       <= fg_d;
            bg_q       <= bg_d;
            clrFg_q    <= clrFg_d;
            clrBg_q    <= clrBg_d;
            sweepCol_q <= sweepCol_d;
            sweepRow_q <= sweepRow_d;
        end
    end

    // Engine write port; contents are never reset.
    always_ff @(posedge clk) begin
        if (memWe && !reset) begin
            mem[memAddr] <= memData;
        end
    end

    // Display read port. The raw RAM read stays reset-free; a separate flag
    // substitutes a default blank cell for reset and off-screen addresses.
    always_ff @(posedge clk) begin
        rdData_q <= mem[characterPos];
        blank_q  <= reset || (characterPos[12:6] >= NUM_COLS) ||
                    (characterPos[5:0] >= NUM_ROWS);
    end

    assign character = blank_q ? BLANK      : rdData_q[13:6];
    assign fgColor   = blank_q ? DEFAULT_FG : rdData_q[5:3];
    assign bgColor   = blank_q ? DEFAULT_BG : rdData_q[2:0];

endmodule
